gshare_predictor: RTL and testbench

//  Parametrised global-history (gshare) branch direction predictor. Holds a table
//  of 2**IDX_W saturating counters indexed by PC XOR global history register (GHR).

---
 rtl/gshare_predictor_if.sv | 30 +++
 rtl/gshare_predictor.sv | 84 ++++++++
 tb/tb_gshare_predictor.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/gshare_predictor_if.sv
// Request/update/status bundle for the gshare direction predictor.
// The fetch/resolution side uses master; the predictor uses slave.
interface gshare_predictor_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned HIST_W = 6,
  parameter int unsigned STAT_W = 16
);
  logic              req_valid;
  logic [PC_W-1:0]   req_pc;
  logic              pred_valid;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic              upd_mispred;
  logic [HIST_W-1:0] ghr;
  logic [STAT_W-1:0] stat_mispred;

  modport master (
    output req_valid, req_pc, upd_valid, upd_idx, upd_taken, upd_mispred,
    input  pred_valid, pred_taken, pred_idx, ghr, stat_mispred
  );

  modport slave (
    input  req_valid, req_pc, upd_valid, upd_idx, upd_taken, upd_mispred,
    output pred_valid, pred_taken, pred_idx, ghr, stat_mispred
  );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: flop table of saturating counters indexed
// by PC ^ GHR, registered 1-cycle prediction, one resolved update per cycle.
module gshare_predictor #(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned HIST_W   = 6,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned INIT_CTR = 2**(CTR_W-1)-1,
  parameter int unsigned STAT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  gshare_predictor_if.slave  bus
);

  localparam int unsigned DEPTH = 2**IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

  if (HIST_W > IDX_W || HIST_W < 1 || CTR_W < 2) begin : g_bad_params
    $error("gshare_predictor: illegal parameters (need 1<=HIST_W<=IDX_W, CTR_W>=2)");
  end

  logic [DEPTH-1:0][CTR_W-1:0] table_q;
  logic [HIST_W-1:0]           ghr_q;
  logic [STAT_W-1:0]           stat_q;
  logic                        pv_q;
  logic                        pt_q;
  logic [IDX_W-1:0]            pidx_q;

  logic [IDX_W-1:0]            req_idx;
  logic [HIST_W:0]             ghr_shift;
  logic [CTR_W-1:0]            upd_ctr;
  logic                        unused_pc_bits;

  assign req_idx        = bus.req_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  // Shifting through a one-wider vector keeps HIST_W=1 legal without a special case.
  assign ghr_shift      = {ghr_q, bus.upd_taken};
  assign upd_ctr        = table_q[bus.upd_idx];
  assign unused_pc_bits = ^{bus.req_pc[PC_W-1:IDX_W+2], bus.req_pc[1:0]};

  // Nonblocking writes give read-before-write: a same-cycle request sees the old counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_q <= {DEPTH{CTR_INIT}};
    end else if (bus.upd_valid) begin
      if (bus.upd_taken) begin
        if (upd_ctr != '1) table_q[bus.upd_idx] <= upd_ctr + CTR_W'(1);
      end else begin
        if (upd_ctr != '0) table_q[bus.upd_idx] <= upd_ctr - CTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q  <= '0;
      stat_q <= '0;
    end else if (bus.upd_valid) begin
      ghr_q <= ghr_shift[HIST_W-1:0];
      if (bus.upd_mispred && stat_q != '1) stat_q <= stat_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q   <= 1'b0;
      pt_q   <= 1'b0;
      pidx_q <= '0;
    end else begin
      pv_q <= bus.req_valid;
      if (bus.req_valid) begin
        pidx_q <= req_idx;
        pt_q   <= table_q[req_idx][CTR_W-1];
      end
    end
  end

  assign bus.pred_valid   = pv_q;
  assign bus.pred_taken   = pt_q;
  assign bus.pred_idx     = pidx_q;
  assign bus.ghr          = ghr_q;
  assign bus.stat_mispred = stat_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios plus randomized
// traffic compared against an integer reference model of the predictor rules.
module tb_gshare_predictor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gshare_predictor_if #(.PC_W(32), .IDX_W(6), .HIST_W(6), .STAT_W(16)) b ();
  gshare_predictor_if #(.PC_W(32), .IDX_W(6), .HIST_W(6), .STAT_W(2))  b2 ();

  gshare_predictor #(.PC_W(32), .IDX_W(6), .HIST_W(6), .CTR_W(2), .INIT_CTR(1), .STAT_W(16))
    dut (.clk(clk), .rst_n(rst_n), .bus(b));
  gshare_predictor #(.PC_W(32), .IDX_W(6), .HIST_W(6), .CTR_W(2), .INIT_CTR(1), .STAT_W(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (default-parameter instance)
  int   mctr [64];
  int   mghr;
  int   mstat;
  logic exp_pv;
  logic exp_pt;
  int   exp_pidx;

  task automatic model_reset();
    foreach (mctr[i]) mctr[i] = 1;
    mghr = 0; mstat = 0; exp_pv = 1'b0; exp_pt = 1'b0; exp_pidx = 0;
  endtask

  task automatic idle();
    b.req_valid = 1'b0; b.req_pc = '0; b.upd_valid = 1'b0; b.upd_idx = '0;
    b.upd_taken = 1'b0; b.upd_mispred = 1'b0;
    b2.req_valid = 1'b0; b2.req_pc = '0; b2.upd_valid = 1'b0; b2.upd_idx = '0;
    b2.upd_taken = 1'b0; b2.upd_mispred = 1'b0;
  endtask

  function automatic int pc_index(input logic [31:0] pc, input int hist);
    return int'((pc >> 2) & 32'h3F) ^ hist;
  endfunction

  // Apply one clock edge; the model sees pre-edge state for the request.
  task automatic step();
    int idx;
    int u;
    if (b.req_valid) begin
      idx      = pc_index(b.req_pc, mghr);
      exp_pidx = idx;
      exp_pt   = (mctr[idx] >= 2);
    end
    exp_pv = b.req_valid;
    if (b.upd_valid) begin
      u = int'(b.upd_idx);
      if (b.upd_taken) mctr[u] = (mctr[u] == 3) ? 3 : mctr[u] + 1;
      else             mctr[u] = (mctr[u] == 0) ? 0 : mctr[u] - 1;
      mghr = (mghr * 2 + int'(b.upd_taken)) % 64;
      if (b.upd_mispred) mstat = (mstat == 65535) ? 65535 : mstat + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++; if (b.pred_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pred_valid got %0d want 0", b.pred_valid); end
    n_checks++; if (b.pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_pred_taken got %0d want 0", b.pred_taken); end
    n_checks++; if (b.pred_idx !== 6'd0) begin n_fail++; $display("FAIL rst_pred_idx got %0d want 0", b.pred_idx); end
    n_checks++; if (b.ghr !== 6'd0) begin n_fail++; $display("FAIL rst_ghr got %0h want 0", b.ghr); end
    n_checks++; if (b.stat_mispred !== 16'd0) begin n_fail++; $display("FAIL rst_stat got %0d want 0", b.stat_mispred); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_predict_basic();
    b.req_valid = 1'b1; b.req_pc = 32'h0;
    step();
    b.req_valid = 1'b0;
    n_checks++; if (b.pred_valid !== 1'b1) begin n_fail++; $display("FAIL basic_pred_valid got %0d want 1", b.pred_valid); end
    n_checks++; if (b.pred_taken !== 1'b0) begin n_fail++; $display("FAIL basic_pred_taken got %0d want 0", b.pred_taken); end
    n_checks++; if (b.pred_idx !== 6'd0) begin n_fail++; $display("FAIL basic_pred_idx got %0d want 0", b.pred_idx); end
    n_checks++; if (b.ghr !== 6'd0) begin n_fail++; $display("FAIL basic_ghr got %0h want 0", b.ghr); end
    step();
    n_checks++; if (b.pred_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got %0d want 0", b.pred_valid); end
  endtask

  task automatic test_train_taken();
    for (int k = 0; k < 3; k++) begin
      b.upd_valid = 1'b1; b.upd_idx = 6'd5; b.upd_taken = 1'b1;
      step();
    end
    idle();
    n_checks++; if (b.ghr !== 6'h07) begin n_fail++; $display("FAIL taken_ghr got %0h want 07", b.ghr); end
    b.req_valid = 1'b1; b.req_pc = 32'h08;
    step();
    idle();
    n_checks++; if (b.pred_idx !== 6'd5) begin n_fail++; $display("FAIL taken_pred_idx got %0d want 5", b.pred_idx); end
    n_checks++; if (b.pred_taken !== 1'b1) begin n_fail++; $display("FAIL taken_pred_taken got %0d want 1", b.pred_taken); end
    step();
    n_checks++; if (b.pred_taken !== 1'b1 || b.pred_idx !== 6'd5) begin n_fail++;
      $display("FAIL hold_pred got taken=%0d idx=%0d want taken=1 idx=5", b.pred_taken, b.pred_idx); end
  endtask

  task automatic test_train_not_taken();
    for (int k = 0; k < 4; k++) begin
      b.upd_valid = 1'b1; b.upd_idx = 6'd5; b.upd_taken = 1'b0;
      step();
    end
    idle();
    n_checks++; if (b.ghr !== 6'h30) begin n_fail++; $display("FAIL nt_ghr got %0h want 30", b.ghr); end
    b.req_valid = 1'b1; b.req_pc = 32'hD4;  // 0x35 ^ 0x30 = 5
    step();
    idle();
    n_checks++; if (b.pred_idx !== 6'd5) begin n_fail++; $display("FAIL nt_pred_idx got %0d want 5", b.pred_idx); end
    n_checks++; if (b.pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt_pred_taken got %0d want 0", b.pred_taken); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    b.req_valid = 1'b1; b.req_pc = 32'h0C;
    b.upd_valid = 1'b1; b.upd_idx = 6'd3; b.upd_taken = 1'b1;
    step();
    idle();
    n_checks++; if (b.pred_taken !== 1'b0) begin n_fail++; $display("FAIL rbw_pred_taken got %0d want 0", b.pred_taken); end
    n_checks++; if (b.pred_idx !== 6'd3) begin n_fail++; $display("FAIL rbw_pred_idx got %0d want 3", b.pred_idx); end
    b.req_valid = 1'b1; b.req_pc = 32'h08;  // 2 ^ ghr(1) = 3
    step();
    idle();
    n_checks++; if (b.pred_taken !== 1'b1) begin n_fail++; $display("FAIL rbw_next_taken got %0d want 1", b.pred_taken); end
    n_checks++; if (b.pred_idx !== 6'd3) begin n_fail++; $display("FAIL rbw_next_idx got %0d want 3", b.pred_idx); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 7; k++) begin
      b.upd_valid = 1'b1; b.upd_idx = 6'(k); b.upd_taken = 1'b1;
      b.req_valid = (k == 6); b.req_pc = 32'h40;
      step();
    end
    idle();
    n_checks++; if (b.ghr !== 6'h3F) begin n_fail++; $display("FAIL ar_ghr_pre got %0h want 3f", b.ghr); end
    n_checks++; if (b.pred_valid !== 1'b1) begin n_fail++; $display("FAIL ar_valid_pre got %0d want 1", b.pred_valid); end
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++; if (b.ghr !== 6'h00) begin n_fail++; $display("FAIL ar_ghr got %0h want 0", b.ghr); end
    n_checks++; if (b.pred_valid !== 1'b0) begin n_fail++; $display("FAIL ar_pred_valid got %0d want 0", b.pred_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_stat_saturate();
    int want;
    idle();
    for (int k = 1; k <= 5; k++) begin
      b2.upd_valid = 1'b1; b2.upd_mispred = 1'b1; b2.upd_idx = 6'd9;
      step();
      want = (k > 3) ? 3 : k;
      n_checks++; if (int'(b2.stat_mispred) != want) begin n_fail++;
        $display("FAIL stat_sat_%0d got %0d want %0d", k, b2.stat_mispred, want); end
    end
    b2.upd_valid = 1'b0; b2.upd_mispred = 1'b1;
    step();
    idle();
    n_checks++; if (b2.stat_mispred !== 2'd3) begin n_fail++; $display("FAIL stat_novalid got %0d want 3", b2.stat_mispred); end
    n_checks++; if (int'(b.stat_mispred) != mstat) begin n_fail++; $display("FAIL stat_main got %0d want %0d", b.stat_mispred, mstat); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      b.req_valid   = ($urandom_range(0, 3) != 0);
      b.req_pc      = $urandom;
      b.upd_valid   = ($urandom_range(0, 3) != 0);
      b.upd_taken   = $urandom_range(0, 1) == 1;
      b.upd_mispred = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 1) == 1) b.upd_idx = 6'(pc_index(b.req_pc, mghr));
      else                            b.upd_idx = 6'($urandom_range(0, 63));
      step();
      n_checks++; if (b.pred_valid !== exp_pv || b.pred_taken !== exp_pt || int'(b.pred_idx) != exp_pidx) begin n_fail++;
        $display("FAIL rand_pred cyc %0d got v=%0d t=%0d i=%0d want v=%0d t=%0d i=%0d", n,
                 b.pred_valid, b.pred_taken, b.pred_idx, exp_pv, exp_pt, exp_pidx); end
      n_checks++; if (int'(b.ghr) != mghr || int'(b.stat_mispred) != mstat) begin n_fail++;
        $display("FAIL rand_state cyc %0d got ghr=%0h stat=%0d want ghr=%0h stat=%0d", n,
                 b.ghr, b.stat_mispred, mghr, mstat); end
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_predict_basic();
    test_train_taken();
    test_train_not_taken();
    test_same_cycle();
    test_async_reset();
    test_stat_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
